// File: rtl/debounce_pkg.sv
// Shared types for the input debouncer.
// State encoding keeps the current debounced level in bit 1, so the Q output
// can be taken straight from the state register.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE_LO = 2'b00,
    ST_WAIT_HI = 2'b01,
    ST_IDLE_HI = 2'b11,
    ST_WAIT_LO = 2'b10
  } DebounceState;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Generic enough to be reused for any async input in the design.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] chain;

  // Shift the raw bit through the flop chain; chain[0] is the metastability catcher
  always_ff @(posedge Clock) begin
    if (Reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], D};
    end
  end

  assign Q = chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Input debouncer: synchronizer followed by a stability-counter FSM.
// Q only changes after the synchronized input has held a new level for
// STABLE_CYCLES consecutive samples; any bounce discards the count.
// Optional feature macro: INPUT_DEBOUNCER_EDGE_EN enables the Rise/Fall
// one-cycle edge pulses; without it both outputs are tied low.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic D,
  output logic Q,
  output logic Busy,
  output logic Rise,
  output logic Fall
);

  // Refuse to elaborate with parameters the counter or synchronizer cannot honour
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_debouncer: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("input_debouncer: STABLE_CYCLES must be >= 2");
  end
  if ((CNT_W < 1) || ((CNT_W < 31) && ((STABLE_CYCLES - 1) >= (1 << CNT_W)))) begin : g_bad_cnt
    $error("input_debouncer: CNT_W too narrow for STABLE_CYCLES-1");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic         syncD;
  DebounceState stateReg;
  DebounceState nextState;
  logic [CNT_W-1:0] cntReg;
  logic [CNT_W-1:0] cntNext;
  logic         busyReg;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .Clock(Clock),
    .Reset(Reset),
    .D    (D),
    .Q    (syncD)
  );

  // State, counter and busy flag registers; reset drops any pending change
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateReg <= ST_IDLE_LO;
      cntReg   <= '0;
      busyReg  <= 1'b0;
    end else begin
      stateReg <= nextState;
      cntReg   <= cntNext;
      busyReg  <= (nextState == ST_WAIT_HI) || (nextState == ST_WAIT_LO);
    end
  end

  // Next-state and counter logic: count consecutive samples at the candidate level
  always_comb begin
    nextState = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      ST_IDLE_LO: begin
        if (syncD) begin
          nextState = ST_WAIT_HI;
          cntNext   = CNT_ONE;
        end
      end
      ST_WAIT_HI: begin
        if (!syncD) begin
          nextState = ST_IDLE_LO;
          cntNext   = '0;
        end else if (cntReg == CNT_LAST) begin
          nextState = ST_IDLE_HI;
          cntNext   = '0;
        end else begin
          cntNext = cntReg + CNT_ONE;
        end
      end
      ST_IDLE_HI: begin
        if (!syncD) begin
          nextState = ST_WAIT_LO;
          cntNext   = CNT_ONE;
        end
      end
      ST_WAIT_LO: begin
        if (syncD) begin
          nextState = ST_IDLE_HI;
          cntNext   = '0;
        end else if (cntReg == CNT_LAST) begin
          nextState = ST_IDLE_LO;
          cntNext   = '0;
        end else begin
          cntNext = cntReg + CNT_ONE;
        end
      end
      default: begin
        nextState = ST_IDLE_LO;
        cntNext   = '0;
      end
    endcase
  end

  assign Q    = stateReg[1];
  assign Busy = busyReg;

`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic riseReg;
  logic fallReg;

  // One-cycle pulses registered on the same edge that commits the new level
  always_ff @(posedge Clock) begin
    if (Reset) begin
      riseReg <= 1'b0;
      fallReg <= 1'b0;
    end else begin
      riseReg <= (stateReg == ST_WAIT_HI) && (nextState == ST_IDLE_HI);
      fallReg <= (stateReg == ST_WAIT_LO) && (nextState == ST_IDLE_LO);
    end
  end

  assign Rise = riseReg;
  assign Fall = fallReg;
`else
  assign Rise = 1'b0;
  assign Fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed testbench for input_debouncer with default parameters.
// Expected Rise/Fall values follow INPUT_DEBOUNCER_EDGE_EN as compiled.
module tb_input_debouncer;

  logic Clock;
  logic Reset;
  logic D;
  logic Q;
  logic Busy;
  logic Rise;
  logic Fall;

`ifdef INPUT_DEBOUNCER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  int checkCount = 0;
  int passCount  = 0;

  input_debouncer #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .CNT_W        (8)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .D    (D),
    .Q    (Q),
    .Busy (Busy),
    .Rise (Rise),
    .Fall (Fall)
  );

  // 20-unit clock period
  initial begin
    Clock = 1'b0;
    forever #10 Clock = ~Clock;
  end

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0b expected %0b", tag, observed, expected);
    end
  endtask

  // Advance one active edge and return at the following falling edge
  task automatic nextEdge();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic applyStimulus(input logic value);
    D = value;
  endtask

  task automatic checkAll(input string tag, input logic expQ, input logic expBusy,
                          input logic expRise, input logic expFall);
    checkOutput({tag, " Q"},    Q,    expQ);
    checkOutput({tag, " Busy"}, Busy, expBusy);
    checkOutput({tag, " Rise"}, Rise, expRise & EDGE_EN);
    checkOutput({tag, " Fall"}, Fall, expFall & EDGE_EN);
  endtask

  initial begin
    Reset = 1'b1;
    D     = 1'b1;
    @(negedge Clock);

    // Reset held for three edges with D high
    for (int e = 0; e < 3; e++) begin
      nextEdge();
      checkAll($sformatf("reset e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    Reset = 1'b0;
    applyStimulus(1'b0);
    repeat (4) nextEdge();
    checkAll("idle low", 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean rise: D changes before edge 0, Q commits after edge 5
    applyStimulus(1'b1);
    for (int e = 0; e <= 6; e++) begin
      nextEdge();
      checkAll($sformatf("rise e%0d", e), (e >= 5), (e >= 2 && e <= 4), (e == 5), 1'b0);
    end

    // Clean fall after stable high
    applyStimulus(1'b0);
    for (int e = 0; e <= 6; e++) begin
      nextEdge();
      checkAll($sformatf("fall e%0d", e), (e < 5), (e >= 2 && e <= 4), 1'b0, (e == 5));
    end

    // Two-cycle glitch is rejected
    applyStimulus(1'b1);
    nextEdge();
    checkAll("glitch e0", 1'b0, 1'b0, 1'b0, 1'b0);
    nextEdge();
    checkAll("glitch e1", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0);
    for (int e = 2; e <= 5; e++) begin
      nextEdge();
      checkAll($sformatf("glitch e%0d", e), 1'b0, (e == 2 || e == 3), 1'b0, 1'b0);
    end

    // Bounce train: 1,0,1,1,0 then steady high
    begin
      logic [4:0] train;
      train = 5'b01101;
      for (int i = 0; i < 5; i++) begin
        applyStimulus(train[i]);
        nextEdge();
        checkOutput($sformatf("bounce %0d Q", i), Q, 1'b0);
        checkOutput($sformatf("bounce %0d Rise", i), Rise, 1'b0);
      end
    end
    applyStimulus(1'b1);
    for (int e = 0; e <= 5; e++) begin
      nextEdge();
      checkOutput($sformatf("bounce settle e%0d Q", e), Q, (e >= 5));
    end
    checkOutput("bounce settle Rise", Rise, EDGE_EN);

    // D toggling every cycle never moves Q
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i[0]);
      nextEdge();
      checkOutput($sformatf("toggle %0d Q", i), Q, 1'b1);
      checkOutput($sformatf("toggle %0d Fall", i), Fall, 1'b0);
    end
    applyStimulus(1'b1);
    repeat (6) nextEdge();
    checkAll("toggle settle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset during WAIT_LO with Q high discards the pending fall
    applyStimulus(1'b0);
    repeat (3) nextEdge();
    checkAll("wait_lo", 1'b1, 1'b1, 1'b0, 1'b0);
    Reset = 1'b1;
    nextEdge();
    checkAll("reset mid-wait", 1'b0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    for (int e = 0; e < 8; e++) begin
      nextEdge();
      checkOutput($sformatf("post reset e%0d Q", e), Q, 1'b0);
      checkOutput($sformatf("post reset e%0d Busy", e), Busy, 1'b0);
    end

    // Recovery: a fresh clean rise after reset still takes six edges
    applyStimulus(1'b1);
    for (int e = 0; e <= 5; e++) begin
      nextEdge();
      checkOutput($sformatf("recover e%0d Q", e), Q, (e >= 5));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
